// File: rtl/spi_target_if.sv
// spi_target_if: bundles the SPI pins and the host-side rx/tx word interface
// of the SPI responder. The slave modport is the responder's view; the master
// modport is the view of whatever drives it (an SPI initiator plus host logic).
interface spi_target_if #(
  parameter int DATA_WIDTH = 8
);

  // SPI pins
  logic                  sck;
  logic                  csn;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;

  // Host-side word interface and status
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  tx_underrun;
  logic                  frame_err;
  logic                  busy;

  modport slave (
    input  sck, csn, mosi, tx_data, tx_valid,
    output miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun, frame_err, busy
  );

  modport master (
    output sck, csn, mosi, tx_data, tx_valid,
    input  miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun, frame_err, busy
  );

endinterface

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 responder (CPOL=0, CPHA=0, active-low chip select).
// SCK/CSN/MOSI are oversampled in the clk domain; MOSI is deserialized into
// DATA_WIDTH-bit words and a one-entry tx buffer feeds the MISO shifter, MSB
// first. When the buffer is empty at a word load, FILL_VALUE is shifted out and
// tx_underrun pulses.
// Optional feature macro: SPI_TARGET_ECHO_EN -- when defined, an empty-buffer
// load shifts out the last completed rx word instead of FILL_VALUE.
module spi_target #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE  = {DATA_WIDTH{1'b1}}
) (
  input logic         clk,
  input logic         rst,
  spi_target_if.slave bus
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] csn_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;
  logic                   csn_d;

  logic sck_s;
  logic csn_s;
  logic mosi_s;
  logic sck_rise;
  logic sck_fall;
  logic csn_rise;
  logic csn_fall;

  // Synchronize the asynchronous SPI pins and keep one extra delayed copy of sck/csn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the csn chain resets to the deselected level (1) so that leaving
      // reset with csn high never looks like a chip-select falling edge.
      sck_sync  <= '0;
      csn_sync  <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      csn_d     <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value,
      // which is what makes this a shift chain rather than a single flop.
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], bus.csn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      csn_d     <= csn_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign csn_s    = csn_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise =  sck_s & ~sck_d;
  assign sck_fall = ~sck_s &  sck_d;
  assign csn_rise =  csn_s & ~csn_d;
  assign csn_fall = ~csn_s &  csn_d;

  // ---------------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------------
  state_t state;
  state_t state_next;

  logic                  start_frame;   // csn fell while idle
  logic                  end_frame;     // csn rose while shifting
  logic                  rx_bit;        // sample mosi on this sck rise
  logic                  tx_reload;     // sck fall after a completed word
  logic                  tx_advance;    // ordinary sck fall: shift tx left

  logic [CNT_W-1:0]      bit_cnt;
  logic                  reload_pending;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  tx_underrun;
  logic                  frame_err;

  logic [DATA_WIDTH-1:0] tx_buf;
  logic                  buf_full;

  logic                  tx_load;
  logic                  consume;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] empty_word;
  logic [DATA_WIDTH-1:0] load_word;
  logic [DATA_WIDTH-1:0] rx_word_next;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-clk event decode; any sck edge coinciding with a csn edge is dropped.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next  = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    rx_bit      = 1'b0;
    tx_reload   = 1'b0;
    tx_advance  = 1'b0;
    unique case (state)
      IDLE: begin
        if (csn_fall) begin
          state_next  = SHIFT;
          start_frame = 1'b1;
        end
      end
      SHIFT: begin
        if (csn_rise) begin
          state_next = IDLE;
          end_frame  = 1'b1;
        end else if (!csn_fall) begin
          if (sck_rise) begin
            rx_bit = 1'b1;
          end else if (sck_fall) begin
            if (reload_pending) begin
              tx_reload = 1'b1;
            end else begin
              tx_advance = 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Word-load source: buffered word if present, otherwise the empty-buffer word.
`ifdef SPI_TARGET_ECHO_EN
  assign empty_word = rx_data;
`else
  assign empty_word = FILL_VALUE;
`endif

  assign tx_load      = start_frame | tx_reload;
  assign consume      = tx_load & buf_full;
  assign load_word    = buf_full ? tx_buf : empty_word;
  assign word_done    = rx_bit && (bit_cnt == LAST_BIT);
  assign rx_word_next = {rx_shift[DATA_WIDTH-2:0], mosi_s};

  // ---------------------------------------------------------------------------
  // Datapath: bit counter, shifters, received word and status pulses
  // ---------------------------------------------------------------------------

  // Receive side: shift mosi in on sck rises, publish each completed word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt        <= '0;
      rx_shift       <= '0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      reload_pending <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (start_frame || end_frame) begin
        // A frame always starts on a word boundary; a partial word at csn
        // release is thrown away and rx_data keeps its last complete value.
        bit_cnt        <= '0;
        rx_shift       <= '0;
        reload_pending <= 1'b0;
      end else if (rx_bit) begin
        rx_shift <= rx_word_next;
        if (word_done) begin
          bit_cnt        <= '0;
          rx_data        <= rx_word_next;
          rx_valid       <= 1'b1;
          reload_pending <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (tx_reload) begin
        reload_pending <= 1'b0;
      end
    end
  end

  // Transmit shifter: load at frame start and after each word, shift on other sck falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift <= '0;
    end else if (end_frame) begin
      // A loaded but unsent word is dropped, never pushed back into the buffer.
      tx_shift <= '0;
    end else if (tx_load) begin
      tx_shift <= load_word;
    end else if (tx_advance) begin
      tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // One-entry tx buffer; a consume in the same clk as a write sees the old (empty) state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_buf   <= '0;
      buf_full <= 1'b0;
    end else if (bus.tx_valid && !buf_full) begin
      tx_buf   <= bus.tx_data;
      buf_full <= 1'b1;
    end else if (consume) begin
      buf_full <= 1'b0;
    end
  end

  // Single-clk status pulses for empty-buffer loads and mid-word deselects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      tx_underrun <= tx_load & ~buf_full;
      frame_err   <= end_frame && (bit_cnt != '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.miso_oe     = (state == SHIFT);
  assign bus.miso        = (state == SHIFT) & tx_shift[DATA_WIDTH-1];
  assign bus.rx_data     = rx_data;
  assign bus.rx_valid    = rx_valid;
  assign bus.tx_ready    = ~buf_full;
  assign bus.tx_underrun = tx_underrun;
  assign bus.frame_err   = frame_err;
  assign bus.busy        = ~csn_s;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed bench for spi_target. The stimulus thread plays an
// SPI mode-0 initiator and host, pushing expected rx words and expected MISO
// words into queues; independent monitors pop and compare when the DUT
// presents rx_valid or when a full MISO word has been clocked out.
`timescale 1ns/1ps
module tb_spi_target;

  localparam int W    = 8;
  localparam int HALF = 50;   // SCK half period: 5 clk periods

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_target_if #(.DATA_WIDTH(W)) bus ();

  spi_target #(
    .DATA_WIDTH (W),
    .SYNC_STAGES(2),
    .FILL_VALUE (8'hFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_rx_q[$];
  logic [W-1:0] exp_miso_q[$];

  int rxv_cnt = 0;
  int und_cnt = 0;
  int ferr_cnt = 0;
  int base_rxv, base_und, base_ferr;

  logic [W-1:0] last_rx;   // model of the last complete received word

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word the DUT should shift out when its tx buffer is empty.
  function automatic logic [W-1:0] empty_word(input logic [W-1:0] prev_rx);
`ifdef SPI_TARGET_ECHO_EN
    return prev_rx;
`else
    return 8'hFF;
`endif
  endfunction

  // rx monitor and status pulse counters.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_valid) begin
        rxv_cnt++;
        if (exp_rx_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got %0h expected none", bus.rx_data);
        end else begin
          check("rx_data", bus.rx_data, exp_rx_q.pop_front());
        end
      end
      if (bus.tx_underrun) und_cnt++;
      if (bus.frame_err)   ferr_cnt++;
    end
  end

  // MISO monitor: sample on sck rise while selected, compare each full word.
  int           mcnt = 0;
  logic [W-1:0] mword = '0;
  always @(posedge bus.sck or posedge bus.csn or posedge rst) begin
    if (rst || bus.csn) begin
      mcnt = 0;
    end else begin
      mword = {mword[W-2:0], bus.miso};
      mcnt++;
      if (mcnt == W) begin
        mcnt = 0;
        if (exp_miso_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL miso_unexpected: got %0h expected none", mword);
        end else begin
          check("miso_word", mword, exp_miso_q.pop_front());
        end
      end
    end
  end

  // Hard time limit so the run can never hang.
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic queue_tx(input logic [W-1:0] d);
    @(negedge clk);
    check("tx_ready_before_write", bus.tx_ready, 1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    check("tx_ready_after_write", bus.tx_ready, 0);
  endtask

  // Mode-0 frame of nbits, MSB first; the last sck fall coincides with csn release.
  task automatic spi_frame(input logic [31:0] data, input int nbits);
    @(negedge clk);
    bus.mosi = data[nbits-1];
    bus.csn  = 1'b0;
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      bus.sck = 1'b1;
      #HALF;
      bus.sck = 1'b0;
      if (i == nbits - 1) bus.csn = 1'b1;
      else                bus.mosi = data[nbits-2-i];
      #HALF;
    end
    bus.mosi = 1'b0;
    #(2*HALF);
  endtask

  task automatic snap();
    base_rxv  = rxv_cnt;
    base_und  = und_cnt;
    base_ferr = ferr_cnt;
  endtask

  task automatic drain_and_count(input string name, input int rxv, input int und, input int ferr);
    int n = 0;
    while ((exp_rx_q.size() != 0 || exp_miso_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check({name, "_pending_expectations"}, exp_rx_q.size() + exp_miso_q.size(), 0);
    exp_rx_q.delete();
    exp_miso_q.delete();
    check({name, "_rx_valid_pulses"},    rxv_cnt  - base_rxv,  rxv);
    check({name, "_tx_underrun_pulses"}, und_cnt  - base_und,  und);
    check({name, "_frame_err_pulses"},   ferr_cnt - base_ferr, ferr);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_miso"},        bus.miso,        0);
    check({name, "_miso_oe"},     bus.miso_oe,     0);
    check({name, "_rx_data"},     bus.rx_data,     0);
    check({name, "_rx_valid"},    bus.rx_valid,    0);
    check({name, "_tx_ready"},    bus.tx_ready,    1);
    check({name, "_tx_underrun"}, bus.tx_underrun, 0);
    check({name, "_frame_err"},   bus.frame_err,   0);
    check({name, "_busy"},        bus.busy,        0);
  endtask

  initial begin
    bus.sck      = 1'b0;
    bus.csn      = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    last_rx      = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single word: tx A5 out, 3C in.
    snap();
    queue_tx(8'hA5);
    exp_miso_q.push_back(8'hA5);
    exp_rx_q.push_back(8'h3C);
    spi_frame(32'h3C, 8);
    last_rx = 8'h3C;
    check("single_tx_ready_refilled", bus.tx_ready, 1);
    check("single_miso_oe_idle", bus.miso_oe, 0);
    drain_and_count("single", 1, 0, 0);

    // Three words, one queued: second and third loads find the buffer empty.
    snap();
    queue_tx(8'h11);
    exp_miso_q.push_back(8'h11);
    exp_miso_q.push_back(empty_word(8'h01));
    exp_miso_q.push_back(empty_word(8'h02));
    exp_rx_q.push_back(8'h01);
    exp_rx_q.push_back(8'h02);
    exp_rx_q.push_back(8'h03);
    spi_frame(32'h010203, 24);
    last_rx = 8'h03;
    check("multi_rx_data_held", bus.rx_data, 8'h03);
    drain_and_count("multi", 3, 2, 0);

    // Empty buffer, two words: second MISO word is FILL (or the echoed 5A).
    snap();
    exp_miso_q.push_back(empty_word(last_rx));
    exp_miso_q.push_back(empty_word(8'h5A));
    exp_rx_q.push_back(8'h5A);
    exp_rx_q.push_back(8'hC3);
    spi_frame(32'h5AC3, 16);
    last_rx = 8'hC3;
    drain_and_count("empty", 2, 2, 0);

    // Deselect after 5 bits of F0: frame_err, rx_data keeps C3.
    snap();
    spi_frame(32'h1E, 5);   // top five bits of F0: 1,1,1,1,0
    check("abort_rx_data_kept", bus.rx_data, 8'hC3);
    check("abort_miso_oe", bus.miso_oe, 0);
    drain_and_count("abort", 0, 1, 1);

    // Next full frame recovers cleanly.
    snap();
    exp_miso_q.push_back(empty_word(last_rx));
    exp_rx_q.push_back(8'h81);
    spi_frame(32'h81, 8);
    last_rx = 8'h81;
    check("recover_rx_data", bus.rx_data, 8'h81);
    drain_and_count("recover", 1, 1, 0);

    // SCK toggling while deselected is ignored.
    snap();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.mosi = i[0];
      bus.sck  = 1'b1;
      #HALF;
      check("desel_miso_oe", bus.miso_oe, 0);
      check("desel_miso", bus.miso, 0);
      bus.sck = 1'b0;
      #HALF;
    end
    check("desel_busy", bus.busy, 0);
    check("desel_rx_data", bus.rx_data, 8'h81);
    drain_and_count("desel", 0, 0, 0);

    // Reset mid-frame with a word still waiting in the tx buffer.
    queue_tx(8'h96);
    @(negedge clk);
    bus.csn  = 1'b0;
    bus.mosi = 1'b1;
    #HALF;
    for (int i = 0; i < 4; i++) begin
      bus.sck = 1'b1;
      #HALF;
      bus.sck = 1'b0;
      #HALF;
    end
    check("midreset_busy_before", bus.busy, 1);
    queue_tx(8'h3C);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("midreset");
    bus.csn  = 1'b1;
    bus.mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_rx = '0;
    repeat (4) @(negedge clk);

    // Fresh frame after reset: buffer was cleared, so the load is an underrun.
    snap();
    exp_miso_q.push_back(empty_word(last_rx));
    exp_rx_q.push_back(8'h7E);
    spi_frame(32'h7E, 8);
    last_rx = 8'h7E;
    check("postreset_rx_data", bus.rx_data, 8'h7E);
    check("postreset_tx_ready", bus.tx_ready, 1);
    drain_and_count("postreset", 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
Synthesizable SPI responder (mode 0: CPOL=0, CPHA=0; active-low chip select) for the far end of the SPI initiator BFM. It oversamples SCK/CSN/MOSI in the system clock domain, deserializes MOSI into words, and serializes a host-supplied word onto MISO. It replaces the trivial echo target in SPI benches and is reusable as a peripheral front end.

Parameters:
DATA_WIDTH, 8, bits per SPI word (>=2); MSB first on both lines.
SYNC_STAGES, 2, synchronizer flops on sck/csn/mosi (>=2).
FILL_VALUE, 8'hFF (DATA_WIDTH bits), word shifted out when no tx word is queued.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  asynchronous active-high reset.
sck  input  1  SPI clock from initiator (asynchronous to clk).
csn  input  1  chip select, active low.
mosi  input  1  serial data from initiator.
miso  output  1  serial data to initiator.
miso_oe  output  1  high while selected; external tri-state enable.
rx_data  output  DATA_WIDTH  last complete received word; held until next word completes.
rx_valid  output  1  one-clk pulse when rx_data updates.
tx_data  input  DATA_WIDTH  next word to transmit.
tx_valid  input  1  tx_data valid.
tx_ready  output  1  one-entry tx buffer empty.
tx_underrun  output  1  one-clk pulse when FILL_VALUE is loaded instead of a queued word.
frame_err  output  1  one-clk pulse when csn deasserts mid-word.
busy  output  1  synchronized csn is low.

Behaviour:
- Reset (async assert, sync deassert): miso=0, miso_oe=0, rx_data=0, rx_valid=0, tx_ready=1, tx_underrun=0, frame_err=0, busy=0; bit counter, shift registers, tx buffer cleared.
- Sync: sck/csn/mosi pass through SYNC_STAGES flops; one extra flop on sck and csn gives edge detects. SCK high and low phases must each be >=2 clk periods.
- tx buffer: tx_valid && tx_ready captures tx_data; tx_ready falls the next clk. Buffer empties when consumed by a word load; tx_ready rises the following clk.
- States: IDLE, SHIFT.
- IDLE: miso=0, miso_oe=0, all sck edges ignored. On csn fall: bit_cnt=0, load tx shifter (buffer word if full, else FILL_VALUE with tx_underrun pulse), miso = shifter MSB, miso_oe=1, busy=1, go to SHIFT. First bit is valid before the first sck rise.
- SHIFT, sck rise: rx_shift <= {rx_shift[W-2:0], mosi_s}; bit_cnt++. On the DATA_WIDTH-th rise, the next clk gives rx_data = complete word and a rx_valid pulse; bit_cnt wraps to 0; reload_pending set.
- SHIFT, sck fall: if reload_pending, load the next word (same buffer/FILL rule as frame start) and clear reload_pending; else shift tx left. miso always equals shifter MSB. Back-to-back words in one frame need no csn toggle.
- csn rise in SHIFT: return to IDLE. If bit_cnt != 0, pulse frame_err and discard the partial word (rx_data unchanged). A loaded but unsent tx word is dropped; the buffer is not refilled from it.
- Simultaneous buffer write and consume in the same clk: the consume sees the pre-write state. If the buffer was empty, FILL_VALUE is used and the new word is captured for the next load. No bypass.
- Reset mid-frame: immediate return to IDLE with reset values. A frame in progress is not resumed; the next csn fall starts fresh.
- An sck edge in the same clk as a csn edge is ignored.

Optional Feature:
SPI_TARGET_ECHO_EN. Defined: an empty-buffer load uses the last completed rx_data (0 after reset) instead of FILL_VALUE; tx_underrun still pulses. Undefined: FILL_VALUE is used.

Test Plan:
- Queue tx 8'hA5; initiator sends 8'h3C in one 8-bit frame -> MISO bits 1,0,1,0,0,1,0,1; rx_data=8'h3C with one rx_valid pulse; tx_ready 0 then back to 1 after frame start.
- Queue 8'h11 only; 3-word frame sending 8'h01,8'h02,8'h03 -> MISO words 8'h11, 8'hFF, 8'hFF; two tx_underrun pulses; three rx_valid pulses with data 01,02,03.
- Echo build with empty buffer: send 8'h5A then 8'hC3 in one frame -> second MISO word 8'h5A.
- csn rises after 5 bits of 8'hF0 -> frame_err pulse, no rx_valid, rx_data keeps previous value; next full frame sending 8'h81 yields rx_data=8'h81.
- sck toggling with csn high -> no rx_valid, miso_oe=0, miso=0.
- Assert rst after 4 bits mid-frame, release, run a new frame sending 8'h7E -> all outputs at reset values during rst; rx_data=8'h7E afterwards.
